// File: rtl/cpu_pkg.sv
// Shared definitions for the mini CPU and its program loader.
// Memory geometry constants and the loader FSM state encoding.
package cpu_pkg;

    localparam int unsigned ADDR_W = 8;
    localparam int unsigned DATA_W = 8;

    typedef enum logic [2:0] {
        LdIdle,
        LdLen,
        LdData,
        LdCsum,
        LdDone,
        LdErr
    } ld_state_e;

endpackage

// File: rtl/prog_loader.sv
// Framed byte-stream loader (length, program bytes, XOR checksum) for instruction memory.
// Holds the CPU in reset until a frame with a matching checksum has been written.
module prog_loader #(
    parameter int unsigned ADDR_W = cpu_pkg::ADDR_W,
    parameter int unsigned DATA_W = cpu_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [DATA_W-1:0] imem_wdata,
    output logic              cpu_reset,
    output logic              busy,
    output logic              done,
    output logic              err
);
    import cpu_pkg::*;

    ld_state_e         state_q, state_d;
    logic [DATA_W-1:0] len_q, len_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] csum_q, csum_d;

    logic              in_ready_q, in_ready_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              cpu_reset_q, cpu_reset_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;

    logic accept;
    logic last_byte;

    assign accept    = in_valid && in_ready_q;
    assign last_byte = (32'(addr_q) + 32'd1) == 32'(len_q);

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        addr_d  = addr_q;
        csum_d  = csum_q;
        we_d    = 1'b0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;

        case (state_q)
            LdIdle, LdDone, LdErr: begin
                if (start) begin
                    state_d = LdLen;
                end
            end
            LdLen: begin
                if (accept) begin
                    len_d = in_data;
                    if (in_data == '0) begin
                        state_d = LdErr;
                    end else begin
                        addr_d  = '0;
                        csum_d  = '0;
                        state_d = LdData;
                    end
                end
            end
            LdData: begin
                if (accept) begin
                    // Write is issued from registers, one cycle after acceptance.
                    we_d    = 1'b1;
                    waddr_d = addr_q;
                    wdata_d = in_data;
                    csum_d  = csum_q ^ in_data;
                    addr_d  = addr_q + 1'b1;
                    if (last_byte) begin
                        state_d = LdCsum;
                    end
                end
            end
            LdCsum: begin
                if (accept) begin
                    state_d = (in_data == csum_q) ? LdDone : LdErr;
                end
            end
            default: state_d = LdIdle;
        endcase

        // Status outputs follow the next state so they are registered with it.
        in_ready_d  = (state_d == LdLen) || (state_d == LdData) || (state_d == LdCsum);
        busy_d      = in_ready_d;
        done_d      = (state_d == LdDone);
        err_d       = (state_d == LdErr);
        cpu_reset_d = (state_d != LdDone);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= LdIdle;
            len_q       <= '0;
            addr_q      <= '0;
            csum_q      <= '0;
            in_ready_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            cpu_reset_q <= 1'b1;
            we_q        <= 1'b0;
            waddr_q     <= '0;
            wdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            addr_q      <= addr_d;
            csum_q      <= csum_d;
            in_ready_q  <= in_ready_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
            cpu_reset_q <= cpu_reset_d;
            we_q        <= we_d;
            waddr_q     <= waddr_d;
            wdata_q     <= wdata_d;
        end
    end

    assign in_ready   = in_ready_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign err        = err_q;
    assign cpu_reset  = cpu_reset_q;
    assign imem_we    = we_q;
    assign imem_addr  = waddr_q;
    assign imem_wdata = wdata_q;

endmodule
